// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings, state type and cell accessor for the 2048 move controller
package game_pkg;

    localparam int         CELL_W   = 4;
    localparam logic [3:0] WIN_TILE = 4'd11;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    typedef enum logic [2:0] {IDLE, PROC, CMP, SPAWN, DONE} state_t;

    // Cell idx = r*4+c of a packed 4x4 board.
    function automatic logic [CELL_W-1:0] cell_at(input logic [63:0] b, input logic [3:0] idx);
        return b[{idx, 2'b00} +: CELL_W];
    endfunction

endpackage

// File: rtl/game_row_push_merge.sv
// rtl/game_row_push_merge.sv - combinational 2048 push/merge of one 4-cell lane
//
// Ports:
//   row        in  16  lane {cell3,cell2,cell1,cell0}
//   push_right in  1   0: tiles slide toward cell0, 1: toward cell3
//   result     out 16  lane after sliding and merging each pair at most once
module game_row_push_merge
    import game_pkg::*;
(
    input  logic [15:0] row,
    input  logic        push_right,
    output logic [15:0] result
);

    logic [CELL_W-1:0] c [4];
    logic [CELL_W-1:0] t [4];
    logic [CELL_W-1:0] o [4];
    logic [2:0]        n;
    logic [2:0]        j;
    logic              skip;

    always_comb begin
        // Reorder so the destination edge is always element 0.
        for (int i = 0; i < 4; i++) begin
            c[i] = push_right ? row[(3-i)*4 +: 4] : row[i*4 +: 4];
        end

        // Compact non-empty cells toward element 0.
        for (int i = 0; i < 4; i++) t[i] = '0;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (c[i] != '0) begin
                t[n[1:0]] = c[i];
                n = n + 3'd1;
            end
        end

        // Merge equal neighbours front to back; a merged tile is not merged again.
        for (int i = 0; i < 4; i++) o[i] = '0;
        j    = '0;
        skip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (t[i] != '0) begin
                if (i < 3 && t[i] == t[(i+1)%4]) begin
                    o[j[1:0]] = (t[i] == 4'hF) ? 4'hF : t[i] + 4'd1;
                    skip      = 1'b1;
                end else begin
                    o[j[1:0]] = t[i];
                end
                j = j + 3'd1;
            end
        end

        for (int i = 0; i < 4; i++) begin
            result[i*4 +: 4] = push_right ? o[3-i] : o[i];
        end
    end

endmodule

// File: rtl/game_move_controller.sv
// rtl/game_move_controller.sv - sequences a 2048 move lane by lane, spawns tiles, tracks game over / win
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   move_valid/move_dir move request (0 left, 1 right, 2 up, 3 down), taken only in IDLE
//   move_ready          high in IDLE
//   new_game            pulse: clear board (aborting any move) and spawn two tiles
//   load_valid/load_board  overwrite the committed board while IDLE
//   board               committed board, cell (r,c) at [(r*4+c)*4 +: 4]
//   move_done/moved     end-of-move pulse and whether the board changed
//   game_over, win      status flags (win is sticky until new_game or load)
module game_move_controller
    import game_pkg::*;
#(
    parameter logic [3:0]  SPAWN_FOUR_MASK = 4'h0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    input  logic        new_game,
    input  logic        load_valid,
    input  logic [63:0] load_board,
    output logic [63:0] board,
    output logic        move_done,
    output logic        moved,
    output logic        game_over,
    output logic        win
);

    state_t      state;
    logic [63:0] work;
    logic [63:0] orig;
    logic [1:0]  dir;
    logic [1:0]  lane;
    logic [1:0]  spawn_cnt;
    logic [3:0]  idx;
    logic [15:0] lfsr;
    logic        load_eval;

    logic [15:0] cur_lane;
    logic [15:0] merged_lane;
    logic [63:0] work_merged;
    logic [15:0] lfsr_next;
    logic [3:0]  spawn_val;
    logic        vert;

    function automatic logic [15:0] get_lane(input logic [63:0] b, input logic [1:0] k,
                                             input logic v);
        logic [15:0] l;
        for (int i = 0; i < 4; i++) begin
            l[i*4 +: 4] = v ? cell_at(b, {2'(i), k}) : cell_at(b, {k, 2'(i)});
        end
        return l;
    endfunction

    function automatic logic [63:0] put_lane(input logic [63:0] b, input logic [1:0] k,
                                             input logic v, input logic [15:0] l);
        logic [63:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (v) r[{2'(i), k, 2'b00} +: 4] = l[i*4 +: 4];
            else   r[{k, 2'(i), 2'b00} +: 4] = l[i*4 +: 4];
        end
        return r;
    endfunction

    // Over when every cell is occupied and no orthogonal neighbours match.
    function automatic logic is_over(input logic [63:0] b);
        logic over;
        over = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (cell_at(b, 4'(i)) == '0) over = 1'b0;
            if ((i % 4) < 3 && cell_at(b, 4'(i)) == cell_at(b, 4'(i + 1))) over = 1'b0;
            if ((i / 4) < 3 && cell_at(b, 4'(i)) == cell_at(b, 4'(i + 4))) over = 1'b0;
        end
        return over;
    endfunction

    function automatic logic has_win(input logic [63:0] b);
        logic w;
        w = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (cell_at(b, 4'(i)) >= WIN_TILE) w = 1'b1;
        end
        return w;
    endfunction

    assign vert        = (dir == DIR_UP) || (dir == DIR_DOWN);
    assign cur_lane    = get_lane(work, lane, vert);
    assign work_merged = put_lane(work, lane, vert, merged_lane);
    assign lfsr_next   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign spawn_val   = (lfsr[7:4] == SPAWN_FOUR_MASK) ? 4'd2 : 4'd1;
    assign move_ready  = (state == IDLE);

    game_row_push_merge u_merge (
        .row        (cur_lane),
        .push_right ((dir == DIR_RIGHT) || (dir == DIR_DOWN)),
        .result     (merged_lane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            board     <= '0;
            work      <= '0;
            orig      <= '0;
            dir       <= DIR_LEFT;
            lane      <= '0;
            spawn_cnt <= '0;
            idx       <= '0;
            lfsr      <= LFSR_SEED;
            load_eval <= 1'b0;
            moved     <= 1'b0;
            move_done <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            lfsr      <= lfsr_next;
            move_done <= 1'b0;
            load_eval <= 1'b0;
            if (new_game) begin
                // Valid from any state; board stays as-is until the new game commits.
                work      <= '0;
                spawn_cnt <= 2'd2;
                idx       <= lfsr[3:0];
                moved     <= 1'b1;
                win       <= 1'b0;
                game_over <= 1'b0;
                state     <= SPAWN;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_eval) begin
                            game_over <= is_over(board);
                            win       <= has_win(board);
                        end
                        if (load_valid) begin
                            board     <= load_board;
                            load_eval <= 1'b1;
                        end else if (move_valid && !game_over) begin
                            work  <= board;
                            orig  <= board;
                            dir   <= move_dir;
                            lane  <= '0;
                            state <= PROC;
                        end
                    end
                    PROC: begin
                        work <= work_merged;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) state <= CMP;
                    end
                    CMP: begin
                        if (work == orig) begin
                            moved     <= 1'b0;
                            move_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            moved     <= 1'b1;
                            spawn_cnt <= 2'd1;
                            idx       <= lfsr[3:0];
                            state     <= SPAWN;
                        end
                    end
                    SPAWN: begin
                        if (cell_at(work, idx) == '0) begin
                            work[{idx, 2'b00} +: 4] <= spawn_val;
                            spawn_cnt               <= spawn_cnt - 2'd1;
                            if (spawn_cnt == 2'd1) begin
                                move_done <= 1'b1;
                                state     <= DONE;
                            end else begin
                                idx <= lfsr[3:0];
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    DONE: begin
                        board     <= work;
                        game_over <= is_over(work);
                        win       <= win | has_win(work);
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_move_controller.sv
// tb/tb_game_move_controller.sv - scoreboard bench for game_move_controller
module tb_game_move_controller;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic        new_game = 1'b0;
    logic        load_valid = 1'b0;
    logic [63:0] load_board = '0;
    logic        move_ready;
    logic [63:0] board;
    logic        move_done;
    logic        moved;
    logic        game_over;
    logic        win;

    game_move_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .new_game   (new_game),
        .load_valid (load_valid),
        .load_board (load_board),
        .board      (board),
        .move_done  (move_done),
        .moved      (moved),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pre;
        logic        mv;
        int          spawns;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [63:0] obs_board;
    logic        obs_moved;
    int          obs_lat;
    logic        obs_ready_high;
    logic        obs_timeout;

    logic [63:0] t_load [4] = '{64'h2211, 64'h1, 64'h0300030003000300, 64'h0300030003000300};
    logic [1:0]  t_dir  [4] = '{DIR_LEFT, DIR_LEFT, DIR_UP, DIR_DOWN};
    logic [63:0] t_pre  [4] = '{64'h32, 64'h1, 64'h0000000004000400, 64'h0400040000000000};
    logic        t_mov  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Number of cells that went from empty to a legal spawn value; -1 on any other change.
    function automatic int count_spawns(input logic [63:0] pre, input logic [63:0] post);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (pre[i*4 +: 4] != post[i*4 +: 4]) begin
                if (pre[i*4 +: 4] == 4'd0 && (post[i*4 +: 4] == 4'd1 || post[i*4 +: 4] == 4'd2))
                    n++;
                else
                    return -1;
            end
        end
        return n;
    endfunction

    task automatic load(input logic [63:0] b);
        @(negedge clk);
        load_valid = 1'b1;
        load_board = b;
        @(negedge clk);
        load_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_move(input logic [1:0] d);
        obs_timeout    = 1'b0;
        obs_ready_high = 1'b0;
        for (int i = 0; i < 50 && !move_ready; i++) @(negedge clk);
        move_valid = 1'b1;
        move_dir   = d;
        @(negedge clk);
        move_valid = 1'b0;
        obs_lat    = 1;
        while (!move_done && obs_lat < 60) begin
            if (move_ready) obs_ready_high = 1'b1;
            @(negedge clk);
            obs_lat++;
        end
        if (!move_done) obs_timeout = 1'b1;
        obs_moved = moved;
        @(negedge clk);
        obs_board = board;
    endtask

    task automatic count_dones(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (move_done) dones++;
        end
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        if (move_done) $display("note: move_done already high at new_game release");
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (board !== 64'h0) begin n_bad++; $display("FAIL reset_board got=%h exp=0", board); end
        n_cmp++; if (move_done !== 1'b0) begin n_bad++; $display("FAIL reset_move_done got=%b exp=0", move_done); end
        n_cmp++; if ({game_over, win, moved} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {game_over, win, moved}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (move_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", move_ready); end
    endtask

    task automatic test_moves();
        exp_t e;
        int   sp;
        for (int k = 0; k < 4; k++) begin
            load(t_load[k]);
            sb.push_back('{pre: t_pre[k], mv: t_mov[k], spawns: (t_mov[k] ? 1 : 0)});
            drive_move(t_dir[k]);
            e  = sb.pop_front();
            sp = count_spawns(e.pre, obs_board);
            n_cmp++; if (obs_timeout !== 1'b0) begin n_bad++; $display("FAIL move%0d_timeout got=%b exp=0", k, obs_timeout); end
            n_cmp++; if (obs_moved !== e.mv) begin n_bad++; $display("FAIL move%0d_moved got=%b exp=%b", k, obs_moved, e.mv); end
            n_cmp++; if (sp !== e.spawns) begin n_bad++; $display("FAIL move%0d_board got=%h exp=%h plus %0d spawn(s)", k, obs_board, e.pre, e.spawns); end
            if (!e.mv) begin
                n_cmp++; if (obs_lat !== 6) begin n_bad++; $display("FAIL move%0d_latency got=%0d exp=6", k, obs_lat); end
                n_cmp++; if (obs_ready_high !== 1'b0) begin n_bad++; $display("FAIL move%0d_ready_busy got=%b exp=0", k, obs_ready_high); end
            end
        end
    endtask

    task automatic test_game_over();
        logic [63:0] cb;
        int          dones;
        for (int i = 0; i < 16; i++) cb[i*4 +: 4] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;
        load(cb);
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL over_set got=%b exp=1", game_over); end
        @(negedge clk);
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        count_dones(10, dones);
        move_valid = 1'b0;
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL over_ignored got=%0d exp=0 move_done", dones); end
        n_cmp++; if (board !== cb) begin n_bad++; $display("FAIL over_board got=%h exp=%h", board, cb); end
        pulse_new_game();
        count_dones(60, dones);
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL newgame_done got=%0d exp=1", dones); end
        n_cmp++; if (count_spawns(64'h0, board) !== 2) begin n_bad++; $display("FAIL newgame_board got=%h exp=two tiles", board); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL newgame_over got=%b exp=0", game_over); end
    endtask

    task automatic test_win();
        exp_t e;
        int   dones;
        load(64'hAA);
        n_cmp++; if (win !== 1'b0) begin n_bad++; $display("FAIL win_pre got=%b exp=0", win); end
        sb.push_back('{pre: 64'hB, mv: 1'b1, spawns: 1});
        drive_move(DIR_LEFT);
        e = sb.pop_front();
        n_cmp++; if (count_spawns(e.pre, obs_board) !== e.spawns) begin n_bad++; $display("FAIL win_board got=%h exp=%h plus 1 spawn", obs_board, e.pre); end
        n_cmp++; if (win !== 1'b1) begin n_bad++; $display("FAIL win_set got=%b exp=1", win); end
        drive_move(DIR_DOWN);
        n_cmp++; if (obs_timeout !== 1'b0) begin n_bad++; $display("FAIL win_move2_timeout got=%b exp=0", obs_timeout); end
        n_cmp++; if (win !== 1'b1) begin n_bad++; $display("FAIL win_sticky got=%b exp=1", win); end
        pulse_new_game();
        count_dones(60, dones);
        n_cmp++; if (win !== 1'b0) begin n_bad++; $display("FAIL win_clear got=%b exp=0", win); end
    endtask

    task automatic test_abort();
        int dones;
        load(64'h2211);
        @(negedge clk);
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        dones = move_done ? 1 : 0;
        begin
            int more;
            count_dones(60, more);
            dones += more;
        end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL abort_done got=%0d exp=1", dones); end
        n_cmp++; if (count_spawns(64'h0, board) !== 2) begin n_bad++; $display("FAIL abort_board got=%h exp=two tiles", board); end
    endtask

    task automatic test_reset_spawn();
        load(64'h2211);
        @(negedge clk);
        move_valid = 1'b1;
        move_dir   = DIR_LEFT;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (board !== 64'h0) begin n_bad++; $display("FAIL rst_board got=%h exp=0", board); end
        n_cmp++; if (move_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", move_ready); end
        n_cmp++; if (move_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", move_done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_moves();
        test_game_over();
        test_win();
        test_abort();
        test_reset_spawn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_move_controller.md
Name: game_move_controller

Overview:
- Sequences a full 2048 move on the 4x4 board by time-sharing one combinational row push/merge unit across the four lanes, one lane per clock.
- After the lanes, it detects whether the board changed and spawns a random tile into an empty cell.
- It also maintains the game-over and win flags.
- It sits between the input/button decoder (move requests) and the VGA renderer (reads `board`).

Parameters:
- SPAWN_FOUR_MASK, 4'h0: a spawn is tile 4 (value 2) when LFSR[7:4] equals this mask, else tile 2 (value 1). This gives a 1/16 chance of a 4.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- move_valid  in  1  move request, sampled only in IDLE
- move_dir  in  2  0 left, 1 right, 2 up, 3 down
- move_ready  out  1  high only in IDLE
- new_game  in  1  one-cycle pulse: clear the board and spawn two tiles
- load_valid  in  1  test/debug: overwrite the board (IDLE only)
- load_board  in  64  board image for load_valid
- board  out  64  committed board; cell (r,c) = board[(r*4+c)*4 +: 4]; 0 = empty, n = tile 2^n
- move_done  out  1  one-cycle pulse at the end of every accepted move or new_game
- moved  out  1  valid with move_done: 1 if the board changed
- game_over  out  1  no empty cell and no equal orthogonal neighbours
- win  out  1  sticky; set when any cell reaches 11 (2048)

Behaviour:
- Reset values: state IDLE, board 0, work 0, orig 0, moved 0, move_done 0, game_over 0, win 0, lfsr LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle in all states.
- Lane mapping, left/right: lane k = row k = {cell(k,3),cell(k,2),cell(k,1),cell(k,0)}; push_right = (dir == right).
- Lane mapping, up/down: lane k = column k = {cell(3,k),cell(2,k),cell(1,k),cell(0,k)}; push_right = (dir == down).
- The merger output is written back through the same mapping.

State machine (work and orig are internal 64-bit registers):
- IDLE
  - Priority: new_game > load_valid > move_valid.
  - new_game: work <= 0, spawn_cnt <= 2, go SPAWN.
  - load_valid: board <= load_board, win/game_over recomputed next cycle, stay IDLE.
  - move_valid && !game_over: work <= board, orig <= board, dir latched, lane <= 0, go PROC.
  - move_valid while game_over is ignored: no move_done.
- PROC: each cycle, work lane[lane] <= merge(work lane[lane]); lane++. After lane 3, go CMP.
- CMP
  - work == orig: moved <= 0, go DONE.
  - Otherwise: moved <= 1, spawn_cnt <= 1, go SPAWN.
- SPAWN
  - On entry, idx <= lfsr[3:0].
  - Each cycle, test cell idx of work. If empty, write the spawn value, decrement spawn_cnt, and re-seed idx from lfsr if spawn_cnt is still non-zero; when it reaches 0, go DONE.
  - If not empty, idx <= idx+1 (wraps 15 to 0).
  - Maximum 16 cycles per tile. An empty cell is guaranteed: a changed move always leaves one, and new_game starts empty.
- DONE
  - board <= work.
  - move_done = 1 for this cycle (moved valid).
  - game_over and win are evaluated on work.
  - Go IDLE.
- Unchanged-move latency: accept at cycle T, PROC T+1..T+4, CMP T+5, move_done at T+6.
- board changes only in DONE or on load, so the renderer never sees intermediate lanes.
- new_game in any non-IDLE state aborts the current move: work <= 0, go SPAWN with spawn_cnt 2. board keeps its old value until DONE.
- new_game clears win and game_over.
- Asynchronous reset mid-move discards everything and returns to the reset values.

Decomposition:
- Shared package (game_pkg): DIR_LEFT/RIGHT/UP/DOWN encodings, CELL_W = 4, WIN_TILE = 11, and state enum IDLE/PROC/CMP/SPAWN/DONE.
- Sub-module: one instance of the existing combinational game_row_push_merge, time-shared across lanes.
- game_over/win detection is combinational logic inside this block.

Test Plan:
- Row 0 = c0..c3 {1,1,2,2}, rest empty, move left → row 0 {2,3,0,0}, moved = 1, exactly one new cell of value 1 or 2, move_done once.
- Board with only cell(0,0) = 1, move left → moved = 0, board unchanged, move_done exactly 6 cycles after the accept cycle, move_ready low in between.
- Column 2 = r0..r3 {3,3,3,3}, move up → column 2 {4,4,0,0}; move down from the same load → {0,0,4,4}.
- Load a full checkerboard of values 1/2 with no equal neighbours → game_over = 1 after the next move attempt/load evaluation; move_valid is then ignored (no move_done). new_game clears it and yields exactly two non-zero cells.
- Load cells (0,0) = 10 and (0,1) = 10, move left → cell(0,0) = 11 and win = 1. win stays 1 after further moves and clears on new_game.
- Assert new_game during PROC, and separately assert rst_n low during SPAWN → the first yields a two-tile board; the second yields board 0, IDLE, move_ready = 1.
